// File: rtl/sc_relu_if.sv
// Bitstream bus for sc_relu_array: control, N input streams, N gated output streams.
// The sat flags are carried only when SC_RELU_SAT_FLAG_EN is defined.
interface sc_relu_if #(
  parameter int N = 4
);
  logic         en;
  logic         clr;
  logic         mode;
  logic [N-1:0] x;
  logic [N-1:0] y;
`ifdef SC_RELU_SAT_FLAG_EN
  logic [N-1:0] sat;

  modport master (output en, output clr, output mode, output x, input y, input sat);
  modport slave  (input en, input clr, input mode, input x, output y, output sat);
`else
  modport master (output en, output clr, output mode, output x, input y);
  modport slave  (input en, input clr, input mode, input x, output y);
`endif
endinterface

// File: rtl/sc_relu_array.sv
// N-channel stochastic-computing ReLU: per-channel saturating sign estimator gating each stream.
// Optional sticky saturation flags are built when SC_RELU_SAT_FLAG_EN is defined.
module sc_relu_array #(
  parameter int N     = 4,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  sc_relu_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MID = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt [N];
  logic             tog;
  logic             adv;
  logic [N-1:0]     y_c;

  // Up on a 1, down on a 0, clamped at both rails.
  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c, input logic up);
    if (up) return (c == CNT_MAX) ? c : c + CNT_ONE;
    else    return (c == '0)      ? c : c - CNT_ONE;
  endfunction

  // True when this step would have pushed the counter past a rail.
  function automatic logic sat_hit(input logic [CNT_W-1:0] c, input logic up);
    return up ? (c == CNT_MAX) : (c == '0);
  endfunction

  assign adv = bus.en & ~bus.clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) cnt[i] <= CNT_MID;
      tog <= 1'b0;
    end else if (bus.clr) begin
      for (int i = 0; i < N; i++) cnt[i] <= CNT_MID;
      tog <= 1'b0;
    end else if (bus.en) begin
      for (int i = 0; i < N; i++) cnt[i] <= sat_step(cnt[i], bus.x[i]);
      tog <= ~tog;
    end
  end

  // Gate decision uses the estimate from before this cycle's update.
  always_comb begin
    y_c = '0;
    for (int i = 0; i < N; i++) begin
      if (adv && reset) y_c[i] = cnt[i][CNT_W-1] ? bus.x[i] : (bus.mode & tog);
    end
  end

  assign bus.y = y_c;

`ifdef SC_RELU_SAT_FLAG_EN
  logic [N-1:0] sat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_q <= '0;
    end else if (bus.clr) begin
      sat_q <= '0;
    end else if (bus.en) begin
      for (int i = 0; i < N; i++) begin
        if (sat_hit(cnt[i], bus.x[i])) sat_q[i] <= 1'b1;
      end
    end
  end

  assign bus.sat = sat_q;
`endif

endmodule

// File: tb/tb_sc_relu_array.sv
// Table-driven bench for sc_relu_array (N=4, CNT_W=4) with an expected-output queue.
module tb_sc_relu_array;

  logic clk;
  logic reset;

  sc_relu_if #(.N(4)) bus();

  sc_relu_array #(.N(4), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       clr;
    logic       mode;
    logic [3:0] x;
    logic [3:0] ey;
    logic [3:0] esat;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] exp_q[$];
  int         checks;
  int         errors;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, act, req);
    end
  endtask

  task automatic add(input logic en, input logic clr, input logic mode, input logic [3:0] x,
                     input logic [3:0] ey, input logic [3:0] esat);
    vec_t v;
    v.en = en; v.clr = clr; v.mode = mode; v.x = x; v.ey = ey; v.esat = esat;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic en, input logic clr, input logic mode, input logic [3:0] x);
    bus.en = en; bus.clr = clr; bus.mode = mode; bus.x = x;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] got;
    checks = 0;
    errors = 0;

    // Phase A: ch0 fed ones, ch1..3 fed zeros, bipolar zero except cycles 10/11.
    for (int k = 0; k < 20; k++) begin
      logic       m;
      logic [3:0] ey;
      logic [3:0] es;
      m  = !(k == 10 || k == 11);
      ey = (k == 0) ? 4'b0001 : ((m && (k % 2 == 1)) ? 4'b1111 : 4'b0001);
      es = (k < 7) ? 4'b0000 : ((k == 7) ? 4'b0001 : 4'b1111);
      add(1'b1, 1'b0, m, 4'b0001, ey, es);
    end
    // Phase B: ch2 climbs from 0, gated for 8 cycles then passes.
    for (int j = 0; j < 10; j++)
      add(1'b1, 1'b0, 1'b0, 4'b0100, (j >= 8) ? 4'b0100 : 4'b0000, 4'b1111);
    add(1'b0, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000);
    // Phase C: mixed channels, one bipolar cycle exposing the gated ones.
    for (int k = 0; k < 7; k++)
      add(1'b1, 1'b0, (k == 5), 4'b0101, (k == 5) ? 4'b1111 : 4'b0101, 4'b0000);
    // Phase D: hold, resume, clr-over-saturation, fresh midpoint.
    for (int k = 0; k < 5; k++)
      add(1'b0, 1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000);
    add(1'b1, 1'b0, 1'b1, 4'b0000, 4'b1010, 4'b0000);
    add(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    add(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    add(1'b1, 1'b0, 1'b1, 4'b0000, 4'b1111, 4'b0000);
    add(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    // Phase E: drive ch0 to max ahead of the mid-stream reset.
    for (int k = 0; k < 8; k++)
      add(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001, (k == 7) ? 4'b0001 : 4'b0000);

    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 4'b1111);
    repeat (2) @(posedge clk);
    #1;
    check("reset_y", bus.y, 4'b0000);
`ifdef SC_RELU_SAT_FLAG_EN
    check("reset_sat", bus.sat, 4'b0000);
`endif
    reset = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].mode, tbl[i].x);
      exp_q.push_back(tbl[i].ey);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty vec=%0d", i);
      end else begin
        got = exp_q.pop_front();
        check($sformatf("y_vec%0d", i), bus.y, got);
      end
      @(posedge clk);
      #1;
`ifdef SC_RELU_SAT_FLAG_EN
      check($sformatf("sat_vec%0d", i), bus.sat, tbl[i].esat);
`endif
    end

    // Mid-stream asynchronous reset pulse between edges.
    drive(1'b1, 1'b0, 1'b1, 4'b1111);
    #1;
    check("pre_reset_y", bus.y, 4'b0001);
    reset = 1'b0;
    #1;
    check("async_reset_y", bus.y, 4'b0000);
`ifdef SC_RELU_SAT_FLAG_EN
    check("async_reset_sat", bus.sat, 4'b0000);
`endif
    reset = 1'b1;
    #1;
    check("post_release_mid", bus.y, 4'b1111);
    bus.x = 4'b0000;
    #1;
    check("post_release_pass0", bus.y, 4'b0000);
    @(posedge clk);
    #1;
    check("post_release_gated", bus.y, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
